// File: rtl/conv_host_bus_master.sv
// Host-side initiator for the conv accelerator bus. Programs a job, streams kernel then
// feature words through a 2-entry prefetch buffer, and captures device outputs into omem.
module conv_host_bus_master #(
  parameter int unsigned FEATURE_MAP_WIDTH  = 128,
  parameter int unsigned FEATURE_MAP_HEIGHT = 128,
  parameter int unsigned BUS_WIDTH          = 32
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 cmd_start,
  input  logic [1:0]           cmd_stride_mode,
  output logic                 cmd_busy,
  output logic                 cmd_done,
  output logic                 protocol_err,
  output logic                 dev_start,
  output logic [1:0]           dev_stride_mode,
  input  logic                 dev_running,
  output logic                 dev_bus_valid,
  input  logic                 dev_bus_ready,
  output logic [BUS_WIDTH-1:0] dev_bus_wdata,
  input  logic                 dev_driving_busses,
  input  logic                 dev_output_valid,
  input  logic [6:0]           dev_output_x,
  input  logic [6:0]           dev_output_y,
  input  logic [BUS_WIDTH-1:0] dev_bus_rdata,
  output logic                 kmem_re,
  output logic [7:0]           kmem_addr,
  input  logic [BUS_WIDTH-1:0] kmem_rdata,
  output logic                 fmem_re,
  output logic [6:0]           fmem_x,
  output logic [6:0]           fmem_y,
  output logic                 fmem_ch,
  input  logic [BUS_WIDTH-1:0] fmem_rdata,
  output logic                 omem_we,
  output logic [6:0]           omem_x,
  output logic [6:0]           omem_y,
  output logic [2:0]           omem_word,
  output logic [BUS_WIDTH-1:0] omem_data
);

  localparam int unsigned KernelWords = 144;
  localparam int unsigned MapPixels   = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT;
  localparam int unsigned CntW        = $clog2(6 * MapPixels + 1);
  localparam logic [CntW-1:0] FeatWordsS1 = CntW'(6 * MapPixels);
  localparam logic [CntW-1:0] FeatWordsS2 = CntW'(6 * MapPixels / 4);
  localparam logic [CntW-1:0] FeatWordsS4 = CntW'(6 * MapPixels / 16);

  typedef enum logic [2:0] {StIdle, StStart, StKernel, StFeature, StDrain, StDone} state_e;

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic [1:0] mode_q;
  logic       running_q;

  // Read-issue sequencer
  logic       iss_feat_q, iss_done_q;
  logic [7:0] iss_k_q;
  logic [2:0] iss_j_q;
  logic [6:0] iss_x_q, iss_y_q;
  logic       pend_q, pend_feat_q;

  // Prefetch buffer
  logic [BUS_WIDTH-1:0] buf_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           occ_q;

  logic [7:0]      hs_k_q;
  logic [CntW-1:0] hs_f_q, cap_cnt_q, feat_words;
  logic [2:0]      cap_idx_q;

  logic       streaming, pop, issue, capture, run_fall;
  logic [7:0] stride, x_next, y_next;

  // Datapath decode: bus handshake, read issue, capture
  always_comb begin
    stride     = 8'd1 << mode_q;
    x_next     = {1'b0, iss_x_q} + stride;
    y_next     = {1'b0, iss_y_q} + stride;
    case (mode_q)
      2'd0:    feat_words = FeatWordsS1;
      2'd1:    feat_words = FeatWordsS2;
      default: feat_words = FeatWordsS4;
    endcase
    streaming     = (state_q == StKernel) || (state_q == StFeature);
    dev_bus_valid = (occ_q != 2'd0) && !dev_driving_busses;
    pop           = dev_bus_valid && dev_bus_ready;
    // Only read when the returning word is guaranteed a free slot.
    issue         = streaming && !iss_done_q &&
                    (({1'b0, occ_q} + {2'b0, pend_q}) < (3'd2 + {2'b0, pop}));
    dev_bus_wdata = dev_bus_valid ? buf_q[rd_ptr_q] : '0;
    kmem_re       = issue && !iss_feat_q;
    fmem_re       = issue && iss_feat_q;
    kmem_addr     = iss_k_q;
    fmem_x        = iss_x_q;
    fmem_y        = iss_y_q + {5'd0, iss_j_q[2:1]};
    fmem_ch       = iss_j_q[0];
    capture       = dev_output_valid && (state_q != StIdle);
    omem_we       = capture;
    omem_x        = capture ? dev_output_x : '0;
    omem_y        = capture ? dev_output_y : '0;
    omem_word     = capture ? cap_idx_q : '0;
    omem_data     = capture ? dev_bus_rdata : '0;
    run_fall      = running_q && !dev_running;
    dev_stride_mode = mode_q;
    protocol_err    = err_q;
  end

  // FSM state register
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // FSM next state and sticky error
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          err_d = (cmd_stride_mode == 2'd3);
          if (cmd_stride_mode != 2'd3) state_d = StStart;
        end
      end
      StStart:   state_d = StKernel;
      StKernel:  if (pop && hs_k_q == 8'(KernelWords - 1)) state_d = StFeature;
      StFeature: if (pop && hs_f_q == feat_words - CntW'(1)) state_d = StDrain;
      StDrain: begin
        if (run_fall) begin
          state_d = StDone;
          if ((cap_cnt_q + CntW'(capture)) != feat_words) err_d = 1'b1;
        end
      end
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (dev_bus_ready && dev_driving_busses) err_d = 1'b1;
  end

  // FSM outputs
  always_comb begin
    cmd_busy  = (state_q != StIdle);
    dev_start = (state_q == StStart);
    cmd_done  = (state_q == StDone);
  end

  // Job control, read sequencer, prefetch buffer and counters
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      err_q       <= 1'b0;
      mode_q      <= 2'd0;
      running_q   <= 1'b0;
      iss_feat_q  <= 1'b0;
      iss_done_q  <= 1'b0;
      iss_k_q     <= '0;
      iss_j_q     <= '0;
      iss_x_q     <= '0;
      iss_y_q     <= '0;
      pend_q      <= 1'b0;
      pend_feat_q <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= '0;
      hs_k_q      <= '0;
      hs_f_q      <= '0;
      cap_cnt_q   <= '0;
      cap_idx_q   <= '0;
    end else begin
      err_q     <= err_d;
      running_q <= dev_running;
      if (state_q == StIdle && cmd_start && cmd_stride_mode != 2'd3) mode_q <= cmd_stride_mode;

      pend_q      <= issue;
      pend_feat_q <= iss_feat_q;
      if (pend_q) begin
        buf_q[wr_ptr_q] <= pend_feat_q ? fmem_rdata : kmem_rdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, pend_q} - {1'b0, pop};

      if (state_q == StStart) begin
        iss_feat_q <= 1'b0;
        iss_done_q <= 1'b0;
        iss_k_q    <= '0;
        iss_j_q    <= '0;
        iss_x_q    <= '0;
        iss_y_q    <= '0;
        hs_k_q     <= '0;
        hs_f_q     <= '0;
        cap_cnt_q  <= CntW'(capture);
        cap_idx_q  <= capture ? 3'd1 : 3'd0;
      end else begin
        if (issue) begin
          if (!iss_feat_q) begin
            if (iss_k_q == 8'(KernelWords - 1)) iss_feat_q <= 1'b1;
            else                                iss_k_q    <= iss_k_q + 8'd1;
          end else if (iss_j_q == 3'd5) begin
            // x outer, y inner; each steps by the stride
            iss_j_q <= '0;
            if (y_next >= 8'(FEATURE_MAP_HEIGHT)) begin
              iss_y_q <= '0;
              if (x_next >= 8'(FEATURE_MAP_WIDTH)) iss_done_q <= 1'b1;
              else                                 iss_x_q    <= x_next[6:0];
            end else begin
              iss_y_q <= y_next[6:0];
            end
          end else begin
            iss_j_q <= iss_j_q + 3'd1;
          end
        end
        if (pop && state_q == StKernel)  hs_k_q <= hs_k_q + 8'd1;
        if (pop && state_q == StFeature) hs_f_q <= hs_f_q + CntW'(1);
        if (capture) begin
          cap_cnt_q <= cap_cnt_q + CntW'(1);
          cap_idx_q <= (cap_idx_q == 3'd5) ? 3'd0 : cap_idx_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_host_bus_master.sv
// Scoreboard bench: the job driver queues expected bus words and captures from a
// reference walk of the job; a negedge monitor pops and compares on every DUT transfer.
module tb_conv_host_bus_master;

  localparam int W = 8;
  localparam int H = 8;

  logic        clk, arst_n_in;
  logic        cmd_start;
  logic [1:0]  cmd_stride_mode;
  logic        cmd_busy, cmd_done, protocol_err, dev_start;
  logic [1:0]  dev_stride_mode;
  logic        dev_running, dev_bus_valid, dev_bus_ready, dev_driving_busses, dev_output_valid;
  logic [31:0] dev_bus_wdata, dev_bus_rdata, kmem_rdata, fmem_rdata, omem_data;
  logic [6:0]  dev_output_x, dev_output_y, fmem_x, fmem_y, omem_x, omem_y;
  logic        kmem_re, fmem_re, fmem_ch, omem_we;
  logic [7:0]  kmem_addr;
  logic [2:0]  omem_word;

  conv_host_bus_master #(
    .FEATURE_MAP_WIDTH (W),
    .FEATURE_MAP_HEIGHT(H),
    .BUS_WIDTH         (32)
  ) dut (
    .clk               (clk),
    .arst_n_in         (arst_n_in),
    .cmd_start         (cmd_start),
    .cmd_stride_mode   (cmd_stride_mode),
    .cmd_busy          (cmd_busy),
    .cmd_done          (cmd_done),
    .protocol_err      (protocol_err),
    .dev_start         (dev_start),
    .dev_stride_mode   (dev_stride_mode),
    .dev_running       (dev_running),
    .dev_bus_valid     (dev_bus_valid),
    .dev_bus_ready     (dev_bus_ready),
    .dev_bus_wdata     (dev_bus_wdata),
    .dev_driving_busses(dev_driving_busses),
    .dev_output_valid  (dev_output_valid),
    .dev_output_x      (dev_output_x),
    .dev_output_y      (dev_output_y),
    .dev_bus_rdata     (dev_bus_rdata),
    .kmem_re           (kmem_re),
    .kmem_addr         (kmem_addr),
    .kmem_rdata        (kmem_rdata),
    .fmem_re           (fmem_re),
    .fmem_x            (fmem_x),
    .fmem_y            (fmem_y),
    .fmem_ch           (fmem_ch),
    .fmem_rdata        (fmem_rdata),
    .omem_we           (omem_we),
    .omem_x            (omem_x),
    .omem_y            (omem_y),
    .omem_word         (omem_word),
    .omem_data         (omem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int hs_seen = 0;
  int exp_kaddr = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  logic        held_pending = 1'b0;
  logic [31:0] held_word = '0;
  logic [31:0] salt = '0;
  logic [31:0] exp_words [$];
  logic [48:0] exp_caps [$];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents encode their own address so the word stream proves the address order.
  function automatic logic [31:0] kmem_word(input logic [7:0] a);
    return {salt[15:0], 8'hA5, a};
  endfunction

  function automatic logic [31:0] fmem_word(input logic [6:0] x, input logic [6:0] y,
                                            input logic ch);
    return {salt[31:16], ch, y, x, 1'b1};
  endfunction

  function automatic logic outs_nonzero();
    return |{cmd_busy, cmd_done, protocol_err, dev_start, dev_stride_mode, dev_bus_valid,
             dev_bus_wdata, kmem_re, kmem_addr, fmem_re, fmem_x, fmem_y, fmem_ch,
             omem_we, omem_x, omem_y, omem_word, omem_data};
  endfunction

  // Host memories: registered read, one cycle latency, junk when not read
  always @(posedge clk) begin
    kmem_rdata <= kmem_re ? kmem_word(kmem_addr) : $urandom;
    fmem_rdata <= fmem_re ? fmem_word(fmem_x, fmem_y, fmem_ch) : $urandom;
  end

  // Monitor: sample mid-cycle, before the edge that commits the transfer
  always @(negedge clk) begin
    logic [31:0] w;
    logic [48:0] c;
    #2;
    if (arst_n_in) begin
      if (dev_driving_busses) check_eq("valid_while_driving", dev_bus_valid, 0);
      if (dev_bus_valid && held_pending) check_eq("held_word", dev_bus_wdata, held_word);
      if (dev_bus_valid && dev_bus_ready) begin
        check_eq("word_expected", exp_words.size() != 0, 1);
        if (exp_words.size() != 0) begin
          w = exp_words.pop_front();
          check_eq("bus_word", dev_bus_wdata, w);
        end
        hs_seen++;
        held_pending = 1'b0;
      end else if (dev_bus_valid) begin
        held_pending = 1'b1;
        held_word    = dev_bus_wdata;
      end
      if (kmem_re) begin
        check_eq("kmem_addr", kmem_addr, exp_kaddr);
        exp_kaddr++;
      end
      if (omem_we) begin
        check_eq("capture_expected", exp_caps.size() != 0, 1);
        if (exp_caps.size() != 0) begin
          c = exp_caps.pop_front();
          check_eq("omem_write", {omem_x, omem_y, omem_word, omem_data}, c);
        end
      end
      if (cmd_done) done_cnt++;
      if (dev_start) start_cnt++;
    end
  end

  task automatic idle_inputs();
    cmd_start          = 1'b0;
    dev_bus_ready      = 1'b0;
    dev_driving_busses = 1'b0;
    dev_output_valid   = 1'b0;
    dev_running        = 1'b0;
  endtask

  task automatic run_job(input logic [1:0] mode, input int ready_pct, input int drv_pct,
                         input int cap_short, input logic exp_err, input int abort_at,
                         input int inj_at);
    int s, tot_f, total, caps_total, caps_sent, base_done, base_start, inj_state;
    logic [2:0] cap_idx;
    logic drv;
    s          = 1 << mode;
    tot_f      = 6 * (W / s) * (H / s);
    total      = 144 + tot_f;
    caps_total = tot_f - cap_short;
    exp_words.delete();
    exp_caps.delete();
    salt = $urandom;
    for (int k = 0; k < 144; k++) exp_words.push_back(kmem_word(8'(k)));
    for (int x = 0; x < W; x += s)
      for (int y = 0; y < H; y += s)
        for (int j = 0; j < 6; j++)
          exp_words.push_back(fmem_word(7'(x), 7'((y + j / 2) % 128), (j % 2) == 1));
    hs_seen = 0; exp_kaddr = 0; held_pending = 1'b0;
    cap_idx = 3'd0; caps_sent = 0; inj_state = 0;
    base_done = done_cnt; base_start = start_cnt;

    cmd_stride_mode = mode;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start   = 1'b0;
    dev_running = 1'b1;
    check_eq("start_pulse", dev_start, 1);
    check_eq("err_cleared_on_start", protocol_err, 0);
    @(negedge clk);
    for (int cyc = 0; cyc < 6000 && done_cnt == base_done; cyc++) begin
      if (abort_at >= 0 && hs_seen >= abort_at) begin
        arst_n_in = 1'b0;
        idle_inputs();
        #1;
        check_eq("abort_outputs_async", outs_nonzero(), 0);
        @(posedge clk);
        #1;
        check_eq("abort_outputs_edge", outs_nonzero(), 0);
        @(negedge clk);
        arst_n_in = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("abort_no_done", done_cnt - base_done, 0);
        check_eq("abort_idle", cmd_busy, 0);
        exp_words.delete();
        exp_caps.delete();
        held_pending = 1'b0;
        return;
      end
      cmd_start = 1'b0;
      if (inj_state == 1) begin
        check_eq("busy_start_ignored", dev_stride_mode, mode);
        inj_state = 2;
      end
      if (inj_at >= 0 && inj_state == 0 && hs_seen >= inj_at) begin
        cmd_start       = 1'b1;
        cmd_stride_mode = 2'd3;
        inj_state       = 1;
      end
      if (hs_seen < total) drv = ($urandom_range(99) < drv_pct);
      else                 drv = (caps_sent < caps_total);
      dev_driving_busses = drv;
      dev_bus_ready      = !drv && ($urandom_range(99) < ready_pct);
      if (drv && caps_sent < caps_total) begin
        dev_output_valid = 1'b1;
        dev_output_x     = 7'($urandom);
        dev_output_y     = 7'($urandom);
        dev_bus_rdata    = $urandom;
        exp_caps.push_back({dev_output_x, dev_output_y, cap_idx, dev_bus_rdata});
        cap_idx = (cap_idx == 3'd5) ? 3'd0 : cap_idx + 3'd1;
        caps_sent++;
      end else begin
        dev_output_valid = 1'b0;
      end
      if (hs_seen >= total && caps_sent >= caps_total && !drv) dev_running = 1'b0;
      @(negedge clk);
    end
    idle_inputs();
    check_eq("done_pulses", done_cnt - base_done, 1);
    check_eq("start_pulses", start_cnt - base_start, 1);
    check_eq("words_left", exp_words.size(), 0);
    check_eq("captures_left", exp_caps.size(), 0);
    check_eq("kmem_reads", exp_kaddr, 144);
    check_eq("job_err", protocol_err, exp_err);
    check_eq("idle_after_done", cmd_busy, 0);
    @(negedge clk);
  endtask

  initial begin
    int base;
    arst_n_in       = 1'b0;
    cmd_stride_mode = 2'd0;
    dev_output_x    = '0;
    dev_output_y    = '0;
    dev_bus_rdata   = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", outs_nonzero(), 0);
    @(negedge clk);
    arst_n_in = 1'b1;
    @(negedge clk);

    run_job(2'd0, 100, 0, 0, 1'b0, -1, -1);
    run_job(2'd2, 100, 0, 0, 1'b0, -1, -1);
    run_job(2'd0, 50, 20, 0, 1'b0, -1, 200);
    run_job(2'd1, 60, 30, 0, 1'b0, -1, -1);

    // Reserved stride mode is refused
    base = start_cnt;
    cmd_stride_mode = 2'd3;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mode3_no_start", start_cnt - base, 0);
    check_eq("mode3_err", protocol_err, 1);
    check_eq("mode3_idle", cmd_busy, 0);

    run_job(2'd2, 80, 10, 0, 1'b0, -1, -1);

    // Device accepting while it owns the bus
    dev_bus_ready = 1'b1;
    dev_driving_busses = 1'b1;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check_eq("ready_driving_err", protocol_err, 1);

    run_job(2'd2, 100, 0, 1, 1'b1, -1, -1);
    run_job(2'd0, 100, 0, 0, 1'b0, 70, -1);
    run_job(2'd0, 70, 10, 0, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
